// File: rtl/regfile_pkg.sv
// Shared types for the register-file write-back path: the queued write entry
// and the write-back source identifier.
package regfile_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  typedef struct packed {
    logic [ADDR_W-1:0] rd;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_MEM = 1'b1
  } wb_src_t;

  function automatic wb_src_t otherSrc(input wb_src_t s);
    return (s == SRC_ALU) ? SRC_MEM : SRC_ALU;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small circular FIFO holding pending write-back entries for one source.
// Push and pop are self-gating, so callers may present push while full.
module wb_fifo
  import regfile_pkg::*;
#(
  parameter int FIFO_DEPTH = 2,
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1),
  localparam int PTR_W = $clog2(FIFO_DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  wb_entry_t        pushEntry,
  input  logic             pop,
  output wb_entry_t        popEntry,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  wb_entry_t        mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wrPtr;
  logic [PTR_W-1:0] rdPtr;
  logic             doPush;
  logic             doPop;

  assign full     = (count == CNT_W'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign doPush   = push && !full;
  assign doPop    = pop && !empty;
  assign popEntry = mem[rdPtr];

  // Depth is a power of two, so the pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + PTR_W'(1);
      if (doPop)  rdPtr <= rdPtr + PTR_W'(1);
      case ({doPush, doPop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= pushEntry;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Merges ALU and load write-backs onto the single register-file write port,
// buffering each source and granting one entry per cycle round-robin.
module regfile_wb_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              aluValid,
  output logic              aluReady,
  input  logic [ADDR_W-1:0] aluRd,
  input  logic [DATA_W-1:0] aluData,
  input  logic              memValid,
  output logic              memReady,
  input  logic [ADDR_W-1:0] memRd,
  input  logic [DATA_W-1:0] memData,
  input  logic              wbStall,
  output logic              isWrite,
  output logic [ADDR_W-1:0] rd,
  output logic [DATA_W-1:0] writeData,
  output logic              grantSrc,
  output logic [1:0]        aluCount,
  output logic [1:0]        memCount
);

  import regfile_pkg::*;

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  wb_entry_t        aluIn;
  wb_entry_t        memIn;
  wb_entry_t        aluHead;
  wb_entry_t        memHead;
  wb_entry_t        grantEntry;
  logic             aluFull;
  logic             aluEmpty;
  logic             memFull;
  logic             memEmpty;
  logic             aluPop;
  logic             memPop;
  logic [CNT_W-1:0] aluCnt;
  logic [CNT_W-1:0] memCnt;
  logic             grantValid;
  wb_src_t          grantSel;
  wb_src_t          rrPtr;
  wb_src_t          grantSrcQ;

  assign aluIn    = '{rd: aluRd, data: aluData};
  assign memIn    = '{rd: memRd, data: memData};
  assign aluReady = !aluFull;
  assign memReady = !memFull;
  assign aluCount = 2'(aluCnt);
  assign memCount = 2'(memCnt);
  assign grantSrc = grantSrcQ;

  wb_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) aluFifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (aluValid),
    .pushEntry (aluIn),
    .pop       (aluPop),
    .popEntry  (aluHead),
    .full      (aluFull),
    .empty     (aluEmpty),
    .count     (aluCnt)
  );

  wb_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) memFifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (memValid),
    .pushEntry (memIn),
    .pop       (memPop),
    .popEntry  (memHead),
    .full      (memFull),
    .empty     (memEmpty),
    .count     (memCnt)
  );

  // rrPtr only breaks ties; a lone non-empty source always wins.
  always_comb begin
    grantValid = 1'b0;
    grantSel   = rrPtr;
    if (!wbStall) begin
      if (!aluEmpty && !memEmpty) begin
        grantValid = 1'b1;
        grantSel   = rrPtr;
      end else if (!aluEmpty) begin
        grantValid = 1'b1;
        grantSel   = SRC_ALU;
      end else if (!memEmpty) begin
        grantValid = 1'b1;
        grantSel   = SRC_MEM;
      end
    end
  end

  assign aluPop     = grantValid && (grantSel == SRC_ALU);
  assign memPop     = grantValid && (grantSel == SRC_MEM);
  assign grantEntry = (grantSel == SRC_MEM) ? memHead : aluHead;

  // Writes to x0 still consume their grant but never raise the enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      isWrite   <= 1'b0;
      rd        <= '0;
      writeData <= '0;
      grantSrcQ <= SRC_ALU;
      rrPtr     <= SRC_ALU;
    end else if (grantValid) begin
      isWrite   <= (grantEntry.rd != '0);
      rd        <= grantEntry.rd;
      writeData <= grantEntry.data;
      grantSrcQ <= grantSel;
      rrPtr     <= otherSrc(grantSel);
    end else begin
      isWrite   <= 1'b0;
    end
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the single register-file write port (isWrite, rd, writeData) between two write-back sources: ALU results (src 0) and load results (src 1).
- Each source pushes through a valid/ready handshake into its own 2-deep FIFO.
- A round-robin arbiter pops one entry per cycle and drives a registered write command.
- Sits between the execute/memory stages and the register file's write port.

Parameters:
- DATA_W, 32, write-data width
- ADDR_W, 5, register index width
- FIFO_DEPTH, 2, entries per source FIFO (power of two, ≥2)

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- aluValid  in  1  ALU write-back request valid
- aluReady  out  1  ALU FIFO can accept
- aluRd  in  ADDR_W  ALU destination register
- aluData  in  DATA_W  ALU result
- memValid  in  1  load write-back request valid
- memReady  out  1  load FIFO can accept
- memRd  in  ADDR_W  load destination register
- memData  in  DATA_W  load result
- wbStall  in  1  suppress grants this cycle (FIFOs still accept)
- isWrite  out  1  register-file write enable, registered
- rd  out  ADDR_W  register-file write index, registered
- writeData  out  DATA_W  register-file write data, registered
- grantSrc  out  1  source of the current write (0 = ALU, 1 = load), registered
- aluCount  out  2  ALU FIFO occupancy
- memCount  out  2  load FIFO occupancy

Behaviour:
- Reset (async, rst_n=0):
  - FIFOs empty, counts 0.
  - isWrite=0, rd=0, writeData=0, grantSrc=0.
  - Round-robin pointer rrPtr=0 (ALU preferred first).
  - aluReady/memReady=1 once out of reset. Reset mid-burst discards all buffered entries.
- Push:
  - Handshake occurs when xValid && xReady at a clk edge; the entry {rd, data} is enqueued.
  - xReady = !full, where "full" means count == FIFO_DEPTH.
  - Same-cycle pop frees a slot only on the next cycle; xReady does not look ahead.
- Pop/arbitration, each cycle with wbStall=0:
  - Only ALU FIFO non-empty → grant ALU.
  - Only load FIFO non-empty → grant load.
  - Both non-empty → grant the source selected by rrPtr, then rrPtr <= ~granted source.
  - Single-source grants also set rrPtr <= ~granted source.
- Write command:
  - The granted entry is popped, and on the same edge isWrite<=1, rd<=entry.rd, writeData<=entry.data, grantSrc<=source.
  - If no grant (both empty or wbStall=1), isWrite<=0; rd/writeData/grantSrc hold their previous values.
- rd=0 entries:
  - Popped and consume a grant, but isWrite<=0 for that cycle (x0 writes are dropped here, not only in the register file).
- Latency:
  - Minimum 2 edges from push handshake to isWrite asserted: push at edge N, pop/register at N+1.
  - One write per cycle maximum, for sustained 1 write/cycle throughput.
- Ordering:
  - FIFO order is preserved per source.
  - Cross-source order follows the arbitration only. Same-rd requests from both sources are not reordered by data age; the pipeline upstream guarantees no WAW across sources.
- Simultaneous push and pop on the same FIFO: count unchanged; the stored entry order is correct.
- wbStall:
  - No pops and rrPtr frozen.
  - Pushes continue until full, then xReady=0.
- Push while not ready: ignored, no state change.
- Counts: aluCount/memCount reflect the registered occupancy (0..FIFO_DEPTH).

Decomposition:
- Package regfile_pkg:
  - Constants DATA_W=32 and ADDR_W=5.
  - Typedef wb_entry_t as a packed struct {rd, data}.
  - Enum wb_src_t {SRC_ALU=0, SRC_MEM=1}.
- Sub-module wb_fifo:
  - Parameterised FIFO_DEPTH; wb_entry_t payload.
  - Signals: push/pop, full/empty, count. Async active-low reset.
  - Instantiated twice.
- Arbiter and output register live in the top-level module.

Test Plan:
- Reset then idle → isWrite=0, aluReady=memReady=1, counts 0. Assert rst_n=0 mid-traffic → all outputs return to reset values immediately.
- Single ALU push rd=5, data=0xDEADBEEF → isWrite=1, rd=5, writeData=0xDEADBEEF, grantSrc=0 exactly 2 edges after handshake, for one cycle.
- Both sources push every cycle (ALU rd=1,2,3…; load rd=17,18,19…) → writes alternate ALU/load/ALU/load (rd 1,17,2,18…), one per cycle, no drops.
- wbStall=1 for 4 cycles while ALU pushes rd=7,8,9 → aluReady drops to 0 after 2 accepted entries. On release, writes rd=7 then 8; rd=9 is accepted only after the first pop frees a slot.
- ALU push rd=0 data=0x1234 followed by rd=3 → no isWrite for the rd=0 entry; the next cycle isWrite=1, rd=3.
- Load FIFO full, memValid held high with new data → data not accepted until memReady=1. The full sequence is written in push order, with no duplicates.
